btb_core: RTL and testbench

Branch target buffer for the fetch path. Combinationally looks up the fetch PC and drives `if_btb_hit`, `if_btb_target` and `if_btb_index` into the IF/PD pipeline register. Trains from resolved taken control transfers in EX, and from PD-stage invalidations when a hit lands on a non-branch. Direction prediction stays in gshare; this block supplies targets only.

---
 rtl/btb_core_pkg.sv | 23 ++
 rtl/btb_core_if.sv | 25 ++
 rtl/btb_match.sv | 24 ++
 rtl/btb_core.sv | 99 +++++++++
 tb/tb_btb_core.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/btb_core_pkg.sv
// Shared constants and types for the branch target buffer, plus the lowest-index
// priority encoder used both for tag matches and for free-entry search.
package btb_core_pkg;

  localparam int unsigned BTB_LEN     = 3;
  localparam int unsigned BTB_ENTRIES = 1 << BTB_LEN;
  localparam int unsigned BTB_TAG_W   = 30;

  typedef logic [BTB_LEN-1:0]     btb_idx_t;
  typedef logic [BTB_TAG_W-1:0]   btb_tag_t;
  typedef logic [BTB_ENTRIES-1:0] btb_vec_t;

  // Lowest set bit wins; returns 0 for an all-zero vector.
  function automatic btb_idx_t first_set(btb_vec_t vec);
    btb_idx_t idx;
    idx = '0;
    for (int i = BTB_ENTRIES - 1; i >= 0; i--) begin
      if (vec[i]) idx = btb_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/btb_core_if.sv
// Fetch lookup, PD invalidation and EX training signals of the branch target buffer.
interface btb_core_if;
  import btb_core_pkg::*;

  logic [31:0] if_pc;
  logic        if_btb_hit;
  logic [31:0] if_btb_target;
  btb_idx_t    if_btb_index;
  logic        pd_btb_inval;
  btb_idx_t    pd_btb_index;
  logic        ex_btb_we;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;

  modport master (
    output if_pc, pd_btb_inval, pd_btb_index, ex_btb_we, ex_pc, ex_target,
    input  if_btb_hit, if_btb_target, if_btb_index
  );

  modport slave (
    input  if_pc, pd_btb_inval, pd_btb_index, ex_btb_we, ex_pc, ex_target,
    output if_btb_hit, if_btb_target, if_btb_index
  );

endinterface

// File: rtl/btb_match.sv
// Fully associative valid/tag compare with lowest-index priority on multiple matches.
module btb_match
  import btb_core_pkg::*;
(
  input  btb_vec_t valid,
  input  btb_tag_t tags [BTB_ENTRIES],
  input  btb_tag_t key,
  output logic     hit,
  output btb_idx_t index
);

  btb_vec_t match;

  always_comb begin
    match = '0;
    for (int i = 0; i < BTB_ENTRIES; i++) begin
      match[i] = valid[i] && (tags[i] == key);
    end
  end

  assign hit   = |match;
  assign index = first_set(match);

endmodule

// File: rtl/btb_core.sv
// Branch target buffer: combinational fetch lookup, trained by taken branches from EX
// and invalidated by PD when a hit lands on a non-branch.
module btb_core
  import btb_core_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  btb_core_if.slave  bus
);

  btb_vec_t    valid_q, valid_d;
  btb_tag_t    tag_q    [BTB_ENTRIES];
  logic [31:0] target_q [BTB_ENTRIES];
  btb_idx_t    rr_ptr_q, rr_ptr_d;

  logic     lk_hit, ex_hit;
  btb_idx_t lk_idx, ex_idx;
  logic     free_hit;
  btb_idx_t free_idx;

  logic     wr_target, wr_tag;
  btb_idx_t wr_idx;

  logic unused_ex_pc;
  assign unused_ex_pc = ^bus.ex_pc[1:0];

  btb_match u_if_match (
    .valid (valid_q),
    .tags  (tag_q),
    .key   (bus.if_pc[31:2]),
    .hit   (lk_hit),
    .index (lk_idx)
  );

  btb_match u_ex_match (
    .valid (valid_q),
    .tags  (tag_q),
    .key   (bus.ex_pc[31:2]),
    .hit   (ex_hit),
    .index (ex_idx)
  );

  assign free_hit = ~&valid_q;
  assign free_idx = first_set(~valid_q);

  // Misaligned fetch PCs never hit.
  always_comb begin
    bus.if_btb_hit    = lk_hit && (bus.if_pc[1:0] == 2'b00);
    bus.if_btb_target = '0;
    bus.if_btb_index  = '0;
    if (bus.if_btb_hit) begin
      bus.if_btb_target = target_q[lk_idx];
      bus.if_btb_index  = lk_idx;
    end
  end

  always_comb begin
    valid_d   = valid_q;
    rr_ptr_d  = rr_ptr_q;
    wr_target = 1'b0;
    wr_tag    = 1'b0;
    wr_idx    = '0;

    if (bus.pd_btb_inval) valid_d[bus.pd_btb_index] = 1'b0;

    // EX is applied after PD so a same-index collision leaves the entry valid.
    if (bus.ex_btb_we) begin
      wr_target = 1'b1;
      if (ex_hit) begin
        wr_idx = ex_idx;
      end else if (free_hit) begin
        wr_tag = 1'b1;
        wr_idx = free_idx;
      end else begin
        wr_tag   = 1'b1;
        wr_idx   = rr_ptr_q;
        rr_ptr_d = rr_ptr_q + 1'b1;
      end
      valid_d[wr_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      valid_q  <= valid_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Tag and target storage is not reset; valid gates every use of it.
  always_ff @(posedge clk) begin
    if (resetn && wr_target) target_q[wr_idx] <= bus.ex_target;
    if (resetn && wr_tag)    tag_q[wr_idx]    <= bus.ex_pc[31:2];
  end

endmodule

// File: tb/tb_btb_core.sv
// Directed bench for btb_core: expected lookups queued at drive time, popped and checked.
module tb_btb_core;
  import btb_core_pkg::*;

  typedef struct {
    string       name;
    logic        hit;
    logic [31:0] target;
    logic [2:0]  index;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  btb_core_if bus ();

  btb_core dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic look(input string name, input logic [31:0] pc, input logic h,
                      input logic [31:0] t, input logic [2:0] i);
    exp_t e;
    bus.if_pc = pc;
    sb.push_back('{name: name, hit: h, target: t, index: i});
    #1;
    e = sb.pop_front();
    check({e.name, ".hit"}, {31'd0, bus.if_btb_hit}, {31'd0, e.hit});
    check({e.name, ".target"}, bus.if_btb_target, e.target);
    check({e.name, ".index"}, {29'd0, bus.if_btb_index}, {29'd0, e.index});
  endtask

  task automatic train(input logic [31:0] pc, input logic [31:0] tgt);
    bus.ex_btb_we = 1'b1;
    bus.ex_pc     = pc;
    bus.ex_target = tgt;
    tick();
    bus.ex_btb_we = 1'b0;
  endtask

  initial begin
    bus.if_pc        = '0;
    bus.pd_btb_inval = 1'b0;
    bus.pd_btb_index = '0;
    bus.ex_btb_we    = 1'b0;
    bus.ex_pc        = '0;
    bus.ex_target    = '0;
    tick();
    tick();
    resetn = 1'b1;
    look("reset", 32'hBFC0_0000, 1'b0, 32'h0, 3'd0);

    // Allocate; same-cycle lookup sees the old (empty) contents.
    bus.ex_btb_we = 1'b1;
    bus.ex_pc     = 32'h8000_0010;
    bus.ex_target = 32'h8000_0100;
    look("alloc_same_cycle", 32'h8000_0010, 1'b0, 32'h0, 3'd0);
    tick();
    bus.ex_btb_we = 1'b0;
    look("alloc", 32'h8000_0010, 1'b1, 32'h8000_0100, 3'd0);

    train(32'h8000_0010, 32'h8000_0200);
    look("retarget", 32'h8000_0010, 1'b1, 32'h8000_0200, 3'd0);

    // Entry 1 still free after the retarget, so fill lands on 1..7 in order.
    for (int k = 1; k < 8; k++) begin
      train(32'h8000_1000 + 32'(16 * k), 32'h9000_0000 + 32'(k));
      look($sformatf("fill%0d", k), 32'h8000_1000 + 32'(16 * k), 1'b1,
           32'h9000_0000 + 32'(k), 3'(k));
    end

    train(32'h8000_2000, 32'hA000_0000);
    look("replace0_old", 32'h8000_0010, 1'b0, 32'h0, 3'd0);
    look("replace0_new", 32'h8000_2000, 1'b1, 32'hA000_0000, 3'd0);

    train(32'h8000_2010, 32'hA000_0001);
    look("replace1_old", 32'h8000_1010, 1'b0, 32'h0, 3'd0);
    look("replace1_new", 32'h8000_2010, 1'b1, 32'hA000_0001, 3'd1);

    bus.pd_btb_inval = 1'b1;
    bus.pd_btb_index = 3'd3;
    tick();
    bus.pd_btb_inval = 1'b0;
    look("inval3", 32'h8000_1030, 1'b0, 32'h0, 3'd0);

    train(32'h8000_2020, 32'hA000_0002);
    look("reuse3", 32'h8000_2020, 1'b1, 32'hA000_0002, 3'd3);

    // Pointer must still be 2 after the free-slot reuse.
    train(32'h8000_2030, 32'hA000_0003);
    look("rr_unchanged", 32'h8000_2030, 1'b1, 32'hA000_0003, 3'd2);
    look("rr_victim", 32'h8000_1020, 1'b0, 32'h0, 3'd0);

    bus.ex_btb_we    = 1'b1;
    bus.ex_pc        = 32'h8000_2030;
    bus.ex_target    = 32'hB000_0000;
    bus.pd_btb_inval = 1'b1;
    bus.pd_btb_index = 3'd2;
    look("collide_old", 32'h8000_2030, 1'b1, 32'hA000_0003, 3'd2);
    tick();
    bus.ex_btb_we    = 1'b0;
    bus.pd_btb_inval = 1'b0;
    look("collide_new", 32'h8000_2030, 1'b1, 32'hB000_0000, 3'd2);

    bus.ex_btb_we    = 1'b1;
    bus.ex_pc        = 32'h8000_2020;
    bus.ex_target    = 32'hB000_0001;
    bus.pd_btb_inval = 1'b1;
    bus.pd_btb_index = 3'd4;
    tick();
    bus.ex_btb_we    = 1'b0;
    bus.pd_btb_inval = 1'b0;
    look("both_ex", 32'h8000_2020, 1'b1, 32'hB000_0001, 3'd3);
    look("both_pd", 32'h8000_1040, 1'b0, 32'h0, 3'd0);

    look("misaligned", 32'h8000_2032, 1'b0, 32'h0, 3'd0);

    resetn        = 1'b0;
    bus.ex_btb_we = 1'b1;
    bus.ex_pc     = 32'h8000_3000;
    bus.ex_target = 32'hC000_0000;
    tick();
    resetn        = 1'b1;
    bus.ex_btb_we = 1'b0;
    look("reset_wins", 32'h8000_3000, 1'b0, 32'h0, 3'd0);
    look("reset_clears", 32'h8000_2030, 1'b0, 32'h0, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
